// File: rtl/i2c_master.sv
// i2c_master: single-byte open-drain I2C master (START, addr+rw, ack, data, ack, STOP).
// Define I2C_CLK_STRETCH_EN to hold timing while a slave keeps SCL low in P2/P3.
module i2c_master #(
   parameter int CLK_DIV = 25,
   parameter int ADDR_W  = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic              i_rw,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [7:0]        i_wdata,
   inout  wire               io_scl,
   inout  wire               io_sda,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_nack,
   output logic [7:0]        o_rdata
);

   localparam int QW = $clog2(CLK_DIV);

   typedef enum logic [3:0] {
      S_IDLE,
      S_START,
      S_ADDR,
      S_AACK,
      S_WRITE,
      S_WACK,
      S_READ,
      S_RACK,
      S_STOP
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [QW-1:0] qcnt;
   logic [1:0]    phase;
   logic [2:0]    bitcnt;
   logic [7:0]    shreg;
   logic [7:0]    wdata_q;
   logic          rw_q;
   logic          ack_q;
   logic          hold;
   logic          tick;
   logic          slot_end;
   logic          sample;
   logic          last_bit;
   logic          scl_oe;
   logic          sda_oe;

`ifdef I2C_CLK_STRETCH_EN
   assign hold = (state != S_IDLE) && phase[1] && !io_scl;
`else
   wire unused_scl = io_scl;
   assign hold = 1'b0;
`endif

   assign tick     = !hold && (qcnt == QW'(CLK_DIV - 1));
   assign slot_end = tick && (phase == 2'd3);
   assign sample   = tick && (phase == 2'd2);
   assign last_bit = (bitcnt == 3'd7);

   assign o_done = (state == S_STOP) && slot_end;
   assign o_busy = (state != S_IDLE) && !o_done;

   assign io_scl = scl_oe ? 1'b0 : 1'bz;
   assign io_sda = sda_oe ? 1'b0 : 1'bz;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         qcnt    <= '0;
         phase   <= '0;
         bitcnt  <= '0;
         shreg   <= '0;
         wdata_q <= '0;
         rw_q    <= 1'b0;
         ack_q   <= 1'b0;
         o_nack  <= 1'b0;
         o_rdata <= '0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE) begin
            qcnt   <= '0;
            phase  <= '0;
            bitcnt <= '0;
            if (i_start) begin
               shreg   <= {i_addr, i_rw};
               wdata_q <= i_wdata;
               rw_q    <= i_rw;
               o_nack  <= 1'b0;
            end
         end else begin
            if (tick) begin
               qcnt  <= '0;
               phase <= phase + 2'd1;
            end else if (!hold) begin
               qcnt <= qcnt + 1'b1;
            end
            if (sample) begin
               if (state == S_AACK || state == S_WACK)
                  ack_q <= io_sda;
               if (state == S_READ)
                  o_rdata <= {o_rdata[6:0], io_sda};
            end
            // bit counter wraps 7->0 as the byte hands over to its ACK slot
            if (slot_end) begin
               if (state inside {S_ADDR, S_WRITE, S_READ})
                  bitcnt <= bitcnt + 3'd1;
               if (state inside {S_ADDR, S_WRITE})
                  shreg <= {shreg[6:0], 1'b0};
               if (state == S_AACK)
                  shreg <= wdata_q;
               if ((state == S_AACK || state == S_WACK) && ack_q)
                  o_nack <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (i_start) state_nx = S_START;
         S_START: if (slot_end) state_nx = S_ADDR;
         S_ADDR:  if (slot_end && last_bit) state_nx = S_AACK;
         S_AACK: begin
            if (slot_end) begin
               if (ack_q)     state_nx = S_STOP;
               else if (rw_q) state_nx = S_READ;
               else           state_nx = S_WRITE;
            end
         end
         S_WRITE: if (slot_end && last_bit) state_nx = S_WACK;
         S_WACK:  if (slot_end) state_nx = S_STOP;
         S_READ:  if (slot_end && last_bit) state_nx = S_RACK;
         S_RACK:  if (slot_end) state_nx = S_STOP;
         S_STOP:  if (slot_end) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // SCL low in P0/P1 of every data/ack slot; START and STOP shape the edges
   always_comb begin
      scl_oe = 1'b0;
      sda_oe = 1'b0;
      unique case (state)
         S_IDLE:  scl_oe = 1'b0;
         S_START: sda_oe = phase[1];
         S_ADDR, S_WRITE: begin
            scl_oe = !phase[1];
            sda_oe = !shreg[7];
         end
         S_STOP: begin
            scl_oe = (phase == 2'd0);
            sda_oe = !phase[1];
         end
         default: scl_oe = !phase[1];
      endcase
   end

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed scoreboard bench for i2c_master.
// A bus monitor records bits between START/STOP and acts as an ACKing slave.
`timescale 1ns/1ps
module tb_i2c_master;

   localparam int CD = 4;

   typedef struct {
      logic [31:0] bits;
      int          nb;
      logic        nack;
      logic [7:0]  rdata;
      int          lat;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_start = 1'b0;
   logic       i_rw = 1'b0;
   logic [6:0] i_addr = '0;
   logic [7:0] i_wdata = '0;
   logic       o_busy;
   logic       o_done;
   logic       o_nack;
   logic [7:0] o_rdata;
   wire        scl;
   wire        sda;
   logic       scl_pull = 1'b0;
   logic       sda_pull = 1'b0;

   pullup (scl);
   pullup (sda);
   assign scl = scl_pull ? 1'b0 : 1'bz;
   assign sda = sda_pull ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   i2c_master #(.CLK_DIV(CD), .ADDR_W(7)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (i_start),
      .i_rw    (i_rw),
      .i_addr  (i_addr),
      .i_wdata (i_wdata),
      .io_scl  (scl),
      .io_sda  (sda),
      .o_busy  (o_busy),
      .o_done  (o_done),
      .o_nack  (o_nack),
      .o_rdata (o_rdata)
   );

   int          total = 0;
   int          bad = 0;
   exp_t        sb[$];
   logic [7:0]  exp_rdata = '0;

   logic        in_txn = 1'b0;
   int          mon_n = 0;
   int          n_start = 0;
   int          n_stop = 0;
   logic [31:0] mon_bits = '0;
   logic        rw_seen = 1'b0;
   logic        ack_addr = 1'b1;
   logic        ack_data = 1'b1;
   logic [7:0]  rd_byte = 8'h3C;

   // Bus monitor plus slave: decisions on each SCL fall for the next bit
   initial begin
      logic ps;
      logic pd;
      int   k;
      ps = 1'b1;
      pd = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_txn   = 1'b0;
            sda_pull = 1'b0;
         end else if (ps && scl && pd && !sda) begin
            in_txn   = 1'b1;
            mon_n    = 0;
            mon_bits = '0;
            n_start++;
         end else if (ps && scl && !pd && sda && in_txn) begin
            in_txn = 1'b0;
            n_stop++;
            if (mon_n > 0) begin
               mon_bits = mon_bits >> 1;
               mon_n--;
            end
         end else if (!ps && scl && in_txn) begin
            mon_bits = {mon_bits[30:0], sda};
            mon_n++;
            if (mon_n == 8) rw_seen = sda;
         end else if (ps && !scl && in_txn) begin
            k = mon_n + 1;
            sda_pull = 1'b0;
            if (k == 9 && ack_addr)
               sda_pull = 1'b1;
            else if (k == 18 && ack_data && !rw_seen)
               sda_pull = 1'b1;
            else if (k >= 10 && k <= 17 && rw_seen && ack_addr)
               sda_pull = !rd_byte[17-k];
         end
         ps = scl;
         pd = sda;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void push(input logic rw, input logic [6:0] a,
                                input logic [7:0] d, input int extra);
      exp_t        e;
      logic [17:0] b18;
      logic [8:0]  b9;
      if (!ack_addr) begin
         b9     = {a, rw, 1'b1};
         e.bits = {23'b0, b9};
         e.nb   = 9;
         e.nack = 1'b1;
         e.lat  = 44 * CD + extra;
      end else if (rw) begin
         b18       = {a, 1'b1, 1'b0, rd_byte, 1'b1};
         e.bits    = {14'b0, b18};
         e.nb      = 18;
         e.nack    = 1'b0;
         e.lat     = 80 * CD + extra;
         exp_rdata = rd_byte;
      end else begin
         b18    = {a, 1'b0, 1'b0, d, !ack_data};
         e.bits = {14'b0, b18};
         e.nb   = 18;
         e.nack = !ack_data;
         e.lat  = 80 * CD + extra;
      end
      e.rdata = exp_rdata;
      sb.push_back(e);
   endfunction

   // mode: 0 plain, 1 i_start pulse while busy, 2 SCL stretch, 3 reset mid-WRITE
   task automatic run_txn(input logic rw, input logic [6:0] a,
                          input logic [7:0] d, input int mode);
      int   lat;
      int   s0;
      int   p0;
      logic got;
      exp_t e;
      s0 = n_start;
      p0 = n_stop;
      @(posedge clk);
      #1;
      i_start = 1'b1;
      i_rw    = rw;
      i_addr  = a;
      i_wdata = d;
      @(negedge clk);
      lat = 0;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      chk("busy_after_accept", {31'b0, o_busy}, 1);
      got = 1'b0;
      while (lat < 2000 && !got) begin
         @(negedge clk);
         lat++;
         if (mode == 1 && lat == 50) begin
            i_start = 1'b1;
            i_addr  = 7'h11;
         end
         if (mode == 1 && lat == 51) i_start = 1'b0;
         if (mode == 2 && lat == 24) scl_pull = 1'b1;
         if (mode == 2 && lat == 34) scl_pull = 1'b0;
         if (mode == 3 && lat == 200) begin
            rst_n = 1'b0;
            #1;
            chk("rst_mid_scl", {31'b0, scl}, 1);
            chk("rst_mid_sda", {31'b0, sda}, 1);
            chk("rst_mid_busy", {31'b0, o_busy}, 0);
            chk("rst_mid_done", {31'b0, o_done}, 0);
            chk("rst_mid_nack", {31'b0, o_nack}, 0);
            chk("rst_mid_rdata", {24'b0, o_rdata}, 0);
            if (sb.size() > 0) e = sb.pop_front();
            exp_rdata = '0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (o_done) got = 1'b1;
      end
      chk("done_seen", {31'b0, got}, 1);
      if (sb.size() == 0) begin
         chk("sb_nonempty", 0, 1);
         return;
      end
      e = sb.pop_front();
      chk("latency", lat, e.lat);
      chk("busy_at_done", {31'b0, o_busy}, 0);
      chk("nack", {31'b0, o_nack}, {31'b0, e.nack});
      chk("rdata", {24'b0, o_rdata}, {24'b0, e.rdata});
      chk("bits", mon_bits, e.bits);
      chk("nbits", mon_n, e.nb);
      chk("starts", n_start - s0, 1);
      chk("stops", n_stop - p0, 1);
      @(negedge clk);
      chk("done_pulse", {31'b0, o_done}, 0);
      chk("nack_hold", {31'b0, o_nack}, {31'b0, e.nack});
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'b0, o_busy}, 0);
      chk("rst_done", {31'b0, o_done}, 0);
      chk("rst_nack", {31'b0, o_nack}, 0);
      chk("rst_rdata", {24'b0, o_rdata}, 0);
      chk("rst_scl", {31'b0, scl}, 1);
      chk("rst_sda", {31'b0, sda}, 1);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      ack_addr = 1'b1;
      ack_data = 1'b1;
      rd_byte  = 8'h3C;
      push(1'b0, 7'h50, 8'hA5, 0);
      run_txn(1'b0, 7'h50, 8'hA5, 0);

      push(1'b1, 7'h50, 8'h00, 0);
      run_txn(1'b1, 7'h50, 8'h00, 0);

      ack_addr = 1'b0;
      push(1'b0, 7'h22, 8'h99, 0);
      run_txn(1'b0, 7'h22, 8'h99, 0);

      ack_addr = 1'b1;
      ack_data = 1'b0;
      push(1'b0, 7'h50, 8'h5A, 0);
      run_txn(1'b0, 7'h50, 8'h5A, 0);

      ack_data = 1'b1;
      push(1'b0, 7'h2B, 8'h81, 0);
      run_txn(1'b0, 7'h2B, 8'h81, 1);

      push(1'b0, 7'h50, 8'hA5, 0);
      run_txn(1'b0, 7'h50, 8'hA5, 3);
      repeat (3) @(posedge clk);

      push(1'b0, 7'h12, 8'hFF, 0);
      run_txn(1'b0, 7'h12, 8'hFF, 0);

`ifdef I2C_CLK_STRETCH_EN
      push(1'b0, 7'h50, 8'hA5, 10);
      run_txn(1'b0, 7'h50, 8'hA5, 2);
`endif

      repeat (4) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
